// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared encodings for the RV32I multi-cycle controller
// Rev 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_IMEM    = 2'd2;
    localparam logic [1:0] TC_DMEM    = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_LUI    = 4'd0,
        CL_AUIPC  = 4'd1,
        CL_JAL    = 4'd2,
        CL_JALR   = 4'd3,
        CL_BRANCH = 4'd4,
        CL_LOAD   = 4'd5,
        CL_STORE  = 4'd6,
        CL_OP_IMM = 4'd7,
        CL_OP     = 4'd8
    } op_class_t;

endpackage

`default_nettype wire

// File: rtl/op_classify.sv
// ============================================================================
// op_classify : maps opcode[6:2]/funct3 to an op class and an illegal flag
// Rev 1.0
// ============================================================================
`default_nettype none

module op_classify
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CL_OP;
        illegal  = 1'b0;
        case (opcode)
            OP_LUI:    op_class = CL_LUI;
            OP_AUIPC:  op_class = CL_AUIPC;
            OP_JAL:    op_class = CL_JAL;
            OP_OP_IMM: op_class = CL_OP_IMM;
            OP_OP:     op_class = CL_OP;
            OP_JALR: begin
                op_class = CL_JALR;
                illegal  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                op_class = CL_BRANCH;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                op_class = CL_LOAD;
                illegal  = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                op_class = CL_STORE;
                illegal  = !(funct3 inside {3'b000, 3'b001, 3'b010});
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic [1:0]       trap_cause
);

    localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    op_class_t        op_cls;
    op_class_t        dec_cls;
    logic             dec_illegal;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [1:0]       cause_q;

    op_classify u_classify (
        .opcode   (opcode),
        .funct3   (funct3),
        .op_class (dec_cls),
        .illegal  (dec_illegal)
    );

    // Every pc_we marks the end of an instruction, so it doubles as the retire strobe.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    alu_a_sel = (op_cls == CL_AUIPC);
                    alu_b_sel = op_cls inside {CL_AUIPC, CL_OP_IMM, CL_LOAD, CL_STORE, CL_JALR};
                    if (op_cls == CL_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_cls == CL_STORE);
                    pc_we    = dmem_ready && (op_cls == CL_STORE);
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (op_cls)
                        CL_LUI:  wb_sel = WB_SEL_IMM;
                        CL_JAL:  begin wb_sel = WB_SEL_LINK; pc_sel = PC_SEL_TARGET; end
                        CL_JALR: begin wb_sel = WB_SEL_LINK; pc_sel = PC_SEL_JALR;   end
                        CL_LOAD: wb_sel = WB_SEL_LOAD;
                        default: wb_sel = WB_SEL_ALU;
                    endcase
                end
                ST_TRAP: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired    = rst ? '0 : retire_cnt;
    assign trap_cause = rst ? TC_NONE : cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            op_cls     <= CL_OP;
            wait_cnt   <= 8'd0;
            retire_cnt <= '0;
            cause_q    <= TC_NONE;
        end else begin
            if (pc_we)
                retire_cnt <= retire_cnt + CNT_ONE;
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state    <= ST_DECODE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state    <= ST_TRAP;
                        cause_q  <= TC_IMEM;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    op_cls <= dec_cls;
                    if (dec_illegal) begin
                        state   <= ST_TRAP;
                        cause_q <= TC_ILLEGAL;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_cls)
                        CL_BRANCH:         state <= ST_FETCH;
                        CL_LOAD, CL_STORE: state <= ST_MEM;
                        default:           state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state    <= (op_cls == CL_STORE) ? ST_FETCH : ST_WB;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state    <= ST_TRAP;
                        cause_q  <= TC_DMEM;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_TRAP;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed instruction sequences checked cycle by cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int TMO = 4;

    localparam logic [4:0] I_LUI    = 5'b01101;
    localparam logic [4:0] I_AUIPC  = 5'b00101;
    localparam logic [4:0] I_JAL    = 5'b11011;
    localparam logic [4:0] I_JALR   = 5'b11001;
    localparam logic [4:0] I_BRANCH = 5'b11000;
    localparam logic [4:0] I_LOAD   = 5'b00000;
    localparam logic [4:0] I_STORE  = 5'b01000;
    localparam logic [4:0] I_OPIMM  = 5'b00100;
    localparam logic [4:0] I_OP     = 5'b01100;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        alu_a;
        logic        alu_b;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        halted;
        logic [1:0]  cause;
        logic [31:0] retired;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  opcode = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic        alu_a_sel, alu_b_sel, rf_we, halted;
    logic [31:0] retired;

    int    total = 0;
    int    bad   = 0;
    int    mcount = 0;
    bit    chk_en = 1'b0;
    outs_t expv;
    outs_t got;
    int    cyc;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .retired(retired), .halted(halted),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en) begin
            got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel,
                   alu_b_sel, rf_we, wb_sel, halted, trap_cause, retired};
            total++;
            if (got !== expv) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input outs_t e, input logic ir, input logic dr, input logic bt);
        imem_ready   = ir;
        dmem_ready   = dr;
        branch_taken = bt;
        expv         = e;
        chk_en       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [4:0] o, input logic [2:0] f);
        case (o)
            I_LUI, I_AUIPC, I_JAL, I_OPIMM, I_OP: return 1'b1;
            I_JALR:   return f == 3'b000;
            I_BRANCH: return !(f == 3'b010 || f == 3'b011);
            I_LOAD:   return f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            I_STORE:  return f <= 3'b010;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        outs_t z = '0;
        rst = 1'b1;
        step(z, 1'b0, 1'b0, 1'b0);
        step(z, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        mcount = 0;
    endtask

    // Trap is sticky: ready inputs held high must not provoke any request.
    task automatic trap_cycles(input logic [1:0] cause);
        outs_t e;
        for (int i = 0; i < 3; i++) begin
            e = '0;
            e.halted  = 1'b1;
            e.cause   = cause;
            e.retired = 32'(mcount);
            step(e, 1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic run_instr(input logic [4:0] opc, input logic [2:0] f3, input logic bt,
                             input int id, input int dd, input bit abort, output int cycles);
        outs_t e;
        bit is_ld, is_st, is_jal, is_jalr;
        cycles = 0;
        opcode = opc;
        funct3 = f3;
        is_ld   = (opc == I_LOAD);
        is_st   = (opc == I_STORE);
        is_jal  = (opc == I_JAL);
        is_jalr = (opc == I_JALR);
        for (int i = 0; i < TMO; i++) begin
            e = '0;
            e.imem_req = 1'b1;
            e.ir_we    = (i == id);
            e.retired  = 32'(mcount);
            step(e, (i == id), 1'b0, 1'b0);
            cycles++;
            if (i == id) break;
        end
        if (id >= TMO) begin trap_cycles(2'd2); return; end
        e = '0;
        e.retired = 32'(mcount);
        step(e, 1'b0, 1'b0, 1'b0);
        cycles++;
        if (!legal(opc, f3)) begin trap_cycles(2'd1); return; end
        e = '0;
        e.retired = 32'(mcount);
        e.alu_a   = (opc == I_AUIPC);
        e.alu_b   = (opc == I_AUIPC) || (opc == I_OPIMM) || is_ld || is_st || is_jalr;
        if (opc == I_BRANCH) begin
            e.pc_we  = 1'b1;
            e.pc_sel = bt ? 2'd1 : 2'd0;
            step(e, 1'b0, 1'b0, bt);
            cycles++;
            mcount++;
            return;
        end
        step(e, 1'b0, 1'b0, bt);
        cycles++;
        if (is_ld || is_st) begin
            for (int i = 0; i < TMO; i++) begin
                if (abort && i == 1) begin
                    rst = 1'b1;
                    step('0, 1'b0, 1'b1, 1'b0);
                    rst = 1'b0;
                    mcount = 0;
                    e = '0;
                    e.imem_req = 1'b1;
                    step(e, 1'b0, 1'b0, 1'b0);
                    return;
                end
                e = '0;
                e.dmem_req = 1'b1;
                e.dmem_we  = is_st;
                e.pc_we    = is_st && (i == dd);
                e.retired  = 32'(mcount);
                step(e, 1'b0, (i == dd), 1'b0);
                cycles++;
                if (i == dd) break;
            end
            if (dd >= TMO) begin trap_cycles(2'd3); return; end
            if (is_st) begin mcount++; return; end
        end
        e = '0;
        e.rf_we   = 1'b1;
        e.pc_we   = 1'b1;
        e.retired = 32'(mcount);
        e.wb_sel  = (opc == I_LUI) ? 2'd3 : (is_jal || is_jalr) ? 2'd2 : is_ld ? 2'd1 : 2'd0;
        e.pc_sel  = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        step(e, 1'b0, 1'b0, 1'b0);
        cycles++;
        mcount++;
    endtask

    initial begin
        do_reset();
        chk("reset_retired", 64'(retired), 64'd0);
        chk("reset_cause", 64'(trap_cause), 64'd0);

        run_instr(I_LUI, 3'b000, 1'b0, 0, 0, 1'b0, cyc);
        chk("lui_cycles", 64'(cyc), 64'd4);
        chk("lui_retired", 64'(retired), 64'd1);

        run_instr(I_BRANCH, 3'b000, 1'b1, 0, 0, 1'b0, cyc);
        chk("beq_taken_cycles", 64'(cyc), 64'd3);
        run_instr(I_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0, cyc);
        chk("beq_not_taken_cycles", 64'(cyc), 64'd3);
        chk("branch_retired", 64'(retired), 64'd3);

        run_instr(I_LOAD,   3'b010, 1'b0, 0, 3, 1'b0, cyc);
        run_instr(I_STORE,  3'b000, 1'b0, 1, 0, 1'b0, cyc);
        run_instr(I_JALR,   3'b000, 1'b0, 0, 0, 1'b0, cyc);
        run_instr(I_JAL,    3'b000, 1'b0, 2, 0, 1'b0, cyc);
        run_instr(I_AUIPC,  3'b000, 1'b0, 0, 0, 1'b0, cyc);
        run_instr(I_OPIMM,  3'b111, 1'b0, 0, 0, 1'b0, cyc);
        run_instr(I_OP,     3'b000, 1'b0, TMO - 1, 0, 1'b0, cyc);
        run_instr(I_BRANCH, 3'b101, 1'b1, 0, 0, 1'b0, cyc);
        run_instr(I_LOAD,   3'b101, 1'b0, 0, TMO - 1, 1'b0, cyc);
        run_instr(I_STORE,  3'b010, 1'b0, 0, 2, 1'b0, cyc);
        chk("mix_retired", 64'(retired), 64'd13);

        run_instr(5'b11111, 3'b000, 1'b0, 0, 0, 1'b0, cyc);
        chk("illegal_op_cause", 64'(trap_cause), 64'd1);
        chk("illegal_op_halted", 64'(halted), 64'd1);
        chk("illegal_op_retired", 64'(retired), 64'd13);
        do_reset();
        run_instr(I_BRANCH, 3'b010, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();
        run_instr(I_LOAD, 3'b011, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();
        run_instr(I_STORE, 3'b011, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();
        run_instr(I_JALR, 3'b001, 1'b0, 0, 0, 1'b0, cyc);
        do_reset();

        run_instr(I_OP, 3'b000, 1'b0, TMO, 0, 1'b0, cyc);
        chk("imem_timeout_cycles", 64'(cyc), 64'd4);
        chk("imem_timeout_cause", 64'(trap_cause), 64'd2);
        do_reset();
        run_instr(I_LOAD, 3'b000, 1'b0, 0, TMO, 1'b0, cyc);
        chk("dmem_timeout_cause", 64'(trap_cause), 64'd3);
        do_reset();

        run_instr(I_LUI, 3'b000, 1'b0, 0, 0, 1'b0, cyc);
        run_instr(I_LOAD, 3'b000, 1'b0, 0, 3, 1'b1, cyc);
        chk("abort_retired", 64'(retired), 64'd0);
        run_instr(I_OP, 3'b000, 1'b0, 0, 0, 1'b0, cyc);
        chk("after_abort_retired", 64'(retired), 64'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
